// File: rtl/ram_read_streamer.sv
// rtl/ram_read_streamer.sv - streams a burst of words from a synchronous RAM read port
//
// Purpose: on start, reads length consecutive words beginning at base_addr
// (address wraps modulo 2**ADDR_WIDTH). The words are delivered on a
// valid/ready output stream, and out_last marks the final word. A 2-entry
// output FIFO absorbs the one-cycle RAM latency so that the stream runs at
// one word per cycle.
//
// Optional feature: define RAM_READ_STREAMER_ABORT_EN to add the abort input.
//
// Ports:
//   clock, reset          single clock; asynchronous active-high reset
//   start, base_addr,     burst request (sampled only while idle)
//   length
//   read_addr             registered address to the RAM read port
//   ram_data              RAM read data, one edge after read_addr is sampled
//   out_valid, out_ready, output word stream
//   out_data, out_last
//   busy, done            burst in progress / one-cycle completion pulse
//   abort                 (RAM_READ_STREAMER_ABORT_EN only) cancel a running burst
module ram_read_streamer #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 16
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] base_addr,
  input  logic [ADDR_WIDTH:0]   length,
`ifdef RAM_READ_STREAMER_ABORT_EN
  input  logic                  abort,
`endif
  output logic [ADDR_WIDTH-1:0] read_addr,
  input  logic [DATA_WIDTH-1:0] ram_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_last,
  output logic                  busy,
  output logic                  done
);

  typedef enum logic {IDLE, RUN} state_t;

  state_t                state;
  logic [ADDR_WIDTH:0]   remaining;     // words still to issue, counting the one on read_addr
  logic                  pending;       // read_addr holds an address that has not been issued yet
  logic                  inflight;      // an issued read returns its data on the coming edge
  logic                  inflight_last;
  logic [DATA_WIDTH-1:0] mem_data [2];
  logic                  mem_last [2];
  logic                  wr_ptr;
  logic                  rd_ptr;
  logic [1:0]            count;
  logic                  pop;
  logic                  issue;
  logic                  abort_now;
  logic [2:0]            occ_after;

`ifdef RAM_READ_STREAMER_ABORT_EN
  assign abort_now = abort && (state == RUN);
`else
  assign abort_now = 1'b0;
`endif

  assign out_valid = (count != 2'd0);
  assign out_data  = out_valid ? mem_data[rd_ptr] : '0;
  assign out_last  = out_valid && mem_last[rd_ptr];
  assign pop       = out_valid && out_ready;

  // The occupancy after this edge counts the word landing from the RAM and
  // drops the word leaving. A read issued now lands one edge later, so it may
  // only go out when that figure leaves room in the 2-entry FIFO.
  assign occ_after = {1'b0, count} + {2'b00, inflight} - {2'b00, pop};
  assign issue     = (state == RUN) && pending && (occ_after < 3'd2);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state         <= IDLE;
      remaining     <= '0;
      pending       <= 1'b0;
      inflight      <= 1'b0;
      inflight_last <= 1'b0;
      read_addr     <= '0;
      mem_data[0]   <= '0;
      mem_data[1]   <= '0;
      mem_last[0]   <= 1'b0;
      mem_last[1]   <= 1'b0;
      wr_ptr        <= 1'b0;
      rd_ptr        <= 1'b0;
      count         <= 2'd0;
      busy          <= 1'b0;
      done          <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            if (length != '0) begin
              state     <= RUN;
              busy      <= 1'b1;
              read_addr <= base_addr;
              remaining <= length;
              pending   <= 1'b1;
            end else begin
              done <= 1'b1;
            end
          end
        end
        RUN: begin
          if (abort_now) begin
            // The RAM may still return data for the last address; dropping
            // inflight makes the streamer ignore that data.
            state    <= IDLE;
            busy     <= 1'b0;
            done     <= 1'b1;
            pending  <= 1'b0;
            inflight <= 1'b0;
            count    <= 2'd0;
            wr_ptr   <= 1'b0;
            rd_ptr   <= 1'b0;
          end else begin
            inflight <= issue;
            if (issue) begin
              inflight_last <= (remaining == (ADDR_WIDTH+1)'(1));
              remaining     <= remaining - (ADDR_WIDTH+1)'(1);
              if (remaining == (ADDR_WIDTH+1)'(1)) begin
                pending <= 1'b0;
              end else begin
                read_addr <= read_addr + ADDR_WIDTH'(1);
              end
            end
            if (inflight) begin
              mem_data[wr_ptr] <= ram_data;
              mem_last[wr_ptr] <= inflight_last;
              wr_ptr           <= ~wr_ptr;
            end
            if (pop) begin
              rd_ptr <= ~rd_ptr;
            end
            count <= count + {1'b0, inflight} - {1'b0, pop};
            if (pop && out_last) begin
              state <= IDLE;
              busy  <= 1'b0;
              done  <= 1'b1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ram_read_streamer.sv
// tb/tb_ram_read_streamer.sv - self-checking bench for ram_read_streamer
module tb_ram_read_streamer;

  logic        clock;
  logic        reset;
  logic        start;
  logic [15:0] base_addr;
  logic [16:0] length;
  logic [15:0] read_addr;
  logic [7:0]  ram_data;
  logic        out_valid;
  logic        out_ready;
  logic [7:0]  out_data;
  logic        out_last;
  logic        busy;
  logic        done;
`ifdef RAM_READ_STREAMER_ABORT_EN
  logic        abort;
`endif

  int checks;
  int errors;

  logic [7:0] ram [0:65535];

  ram_read_streamer #(.DATA_WIDTH(8), .ADDR_WIDTH(16)) dut (
    .clock     (clock),
    .reset     (reset),
    .start     (start),
    .base_addr (base_addr),
    .length    (length),
`ifdef RAM_READ_STREAMER_ABORT_EN
    .abort     (abort),
`endif
    .read_addr (read_addr),
    .ram_data  (ram_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_last  (out_last),
    .busy      (busy),
    .done      (done)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Synchronous-read RAM model: one edge of latency.
  always @(posedge clock) ram_data <= ram[read_addr];

  // Starts a burst at the current negedge and follows it to completion.
  // mode 0: ready always high, 1: ready pattern 1,0,0, 2: random ready plus
  // stray start pulses that must be ignored while the burst runs.
  task automatic do_burst(input logic [15:0] base, input logic [16:0] len, input int mode,
                          output logic [15:0] addr_log [4]);
    logic [7:0] exp_q[$];
    int         cyc, got, dones, bound;
    logic       r, held_v, held_l, finished;
    logic [7:0] held_d;
    for (int k = 0; k < int'(len); k++) exp_q.push_back(ram[(int'(base) + k) & 16'hFFFF]);
    start = 1'b1; base_addr = base; length = len; out_ready = 1'b0;
    @(negedge clock);
    start = 1'b0;
    checks++;
    if (busy !== (len != 0)) begin
      errors++; $display("FAIL busy_after_start: got %b expected %b", busy, (len != 0));
    end
    cyc = 0; got = 0; dones = 0; held_v = 0; held_d = 0; held_l = 0; finished = 0;
    bound = 20 + 4 * int'(len);
    while (!finished && cyc < bound) begin
      if (cyc < 4) addr_log[cyc] = read_addr;
      if (done) dones++;
      if (cyc < 2) begin
        checks++;
        if (out_valid !== 1'b0) begin
          errors++; $display("FAIL early_valid: cycle %0d got %b expected 0", cyc, out_valid);
        end
      end
      if (cyc == 2 && len != 0) begin
        checks++;
        if (out_valid !== 1'b1) begin
          errors++; $display("FAIL first_valid_latency: got %b expected 1", out_valid);
        end
      end
      if (held_v) begin
        checks++;
        if (out_valid !== 1'b1 || out_data !== held_d || out_last !== held_l) begin
          errors++;
          $display("FAIL stall_hold: got v=%b d=%h l=%b expected v=1 d=%h l=%b",
                   out_valid, out_data, out_last, held_d, held_l);
        end
      end
      if (got == int'(len)) begin
        finished = 1;
        start = 1'b0;
        checks++;
        if (done !== 1'b1 || busy !== 1'b0 || out_valid !== 1'b0) begin
          errors++;
          $display("FAIL done_at_end: got done=%b busy=%b valid=%b expected 1 0 0", done, busy, out_valid);
        end
      end else begin
        case (mode)
          0: r = 1'b1;
          1: r = (cyc % 3) == 0;
          default: r = ($urandom_range(0, 3) != 0);
        endcase
        out_ready = r;
        if (mode == 2) begin
          start = $urandom_range(0, 1) == 1;
          base_addr = 16'($urandom);
          length = 17'($urandom_range(0, 20));
        end
        if (out_valid && r) begin
          checks++;
          if (out_data !== exp_q[got] || out_last !== (got == int'(len) - 1)) begin
            errors++;
            $display("FAIL word_%0d: got d=%h l=%b expected d=%h l=%b",
                     got, out_data, out_last, exp_q[got], (got == int'(len) - 1));
          end
          got++;
        end
        held_v = out_valid && !r;
        held_d = out_data;
        held_l = out_last;
      end
      if (!finished) begin
        @(negedge clock);
        cyc++;
      end
    end
    if (!finished) begin
      errors++; checks++;
      $display("FAIL burst_timeout: got %0d words expected %0d", got, len);
    end
    start = 1'b0;
    out_ready = 1'b0;
    @(negedge clock);
    checks++;
    if (dones != 1 || done !== 1'b0 || out_valid !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL done_single_pulse: got pulses=%0d done_after=%b valid=%b busy=%b expected 1 0 0 0",
               dones, done, out_valid, busy);
    end
  endtask

  task automatic test_reset;
    checks++;
    if (read_addr !== 16'h0 || out_valid !== 1'b0 || out_data !== 8'h0 || out_last !== 1'b0 ||
        busy !== 1'b0 || done !== 1'b0) begin
      errors++;
      $display("FAIL reset_state: got addr=%h v=%b d=%h l=%b busy=%b done=%b expected all 0",
               read_addr, out_valid, out_data, out_last, busy, done);
    end
  endtask

  task automatic test_basic;
    logic [15:0] al [4];
    do_burst(16'h0010, 17'd4, 0, al);
  endtask

  task automatic test_stall;
    logic [15:0] al [4];
    do_burst(16'h0040, 17'd8, 1, al);
  endtask

  task automatic test_wrap;
    logic [15:0] al [4];
    logic [15:0] exp_a [4];
    exp_a = '{16'hFFFE, 16'hFFFF, 16'h0000, 16'h0001};
    do_burst(16'hFFFE, 17'd4, 0, al);
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (al[i] !== exp_a[i]) begin
        errors++; $display("FAIL wrap_addr_%0d: got %h expected %h", i, al[i], exp_a[i]);
      end
    end
  endtask

  task automatic test_empty;
    logic [15:0] al [4];
    do_burst(16'h0123, 17'd0, 0, al);
  endtask

  task automatic test_reset_mid;
    logic [15:0] al [4];
    int hs;
    start = 1'b1; base_addr = 16'h0200; length = 17'd8; out_ready = 1'b1;
    @(negedge clock);
    start = 1'b0;
    hs = 0;
    for (int c = 0; c < 30 && !(hs == 2 && out_valid); c++) begin
      if (out_valid && out_ready) hs++;
      @(negedge clock);
    end
    checks++;
    if (out_valid !== 1'b1 || out_data !== ram[16'h0202]) begin
      errors++; $display("FAIL mid_word3: got v=%b d=%h expected v=1 d=%h", out_valid, out_data, ram[16'h0202]);
    end
    reset = 1'b1;
    #1;
    test_reset();
    #1 reset = 1'b0;
    out_ready = 1'b0;
    do_burst(16'h0300, 17'd5, 0, al);
  endtask

  task automatic test_random;
    logic [15:0] al [4];
    for (int i = 0; i < 65536; i++) ram[i] = 8'($urandom);
    for (int b = 0; b < 8; b++) begin
      do_burst(16'($urandom), 17'($urandom_range(1, 12)), 2, al);
    end
  endtask

`ifdef RAM_READ_STREAMER_ABORT_EN
  task automatic test_abort;
    logic [15:0] al [4];
    int hs;
    abort = 1'b1;
    @(negedge clock);
    abort = 1'b0;
    checks++;
    if (done !== 1'b0 || busy !== 1'b0) begin
      errors++; $display("FAIL abort_idle: got done=%b busy=%b expected 0 0", done, busy);
    end
    start = 1'b1; base_addr = 16'h0500; length = 17'd6; out_ready = 1'b1;
    @(negedge clock);
    start = 1'b0;
    hs = 0;
    for (int c = 0; c < 30 && !(hs == 1 && out_valid); c++) begin
      if (out_valid && out_ready) hs++;
      @(negedge clock);
    end
    abort = 1'b1;
    out_ready = 1'b0;
    @(negedge clock);
    abort = 1'b0;
    checks++;
    if (out_valid !== 1'b0 || done !== 1'b1 || busy !== 1'b0) begin
      errors++; $display("FAIL abort_edge: got v=%b done=%b busy=%b expected 0 1 0", out_valid, done, busy);
    end
    out_ready = 1'b1;
    for (int c = 0; c < 5; c++) begin
      @(negedge clock);
      checks++;
      if (out_valid !== 1'b0 || done !== 1'b0) begin
        errors++; $display("FAIL abort_quiet: got v=%b done=%b expected 0 0", out_valid, done);
      end
    end
    do_burst(16'h0600, 17'd6, 0, al);
  endtask
`endif

  initial begin
    checks = 0;
    errors = 0;
    reset = 1'b1; start = 1'b0; base_addr = '0; length = '0; out_ready = 1'b0;
`ifdef RAM_READ_STREAMER_ABORT_EN
    abort = 1'b0;
`endif
    for (int i = 0; i < 65536; i++) ram[i] = 8'(i);
    repeat (3) @(negedge clock);
    test_reset();
    reset = 1'b0;
    test_basic();
    test_stall();
    test_wrap();
    test_empty();
    test_reset_mid();
`ifdef RAM_READ_STREAMER_ABORT_EN
    test_abort();
`endif
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/ram_read_streamer.md
RAM_READ_STREAMER -- requirements
Module: ram_read_streamer

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 8: word width; matches the RAM data width.
REQ-002 SHALL have parameter ADDR_WIDTH, default 16: RAM address width.
REQ-003 SHALL have ports: clock  input  1  single clock, all state on rising edge.
REQ-004 SHALL have ports: reset  input  1  asynchronous, active-high; clears all state.
REQ-005 SHALL have ports: start  input  1  burst request, sampled only when idle.
REQ-006 SHALL have ports: base_addr  input  ADDR_WIDTH  first word address, sampled with start.
REQ-007 SHALL have ports: length  input  ADDR_WIDTH+1  word count, sampled with start; 0 = empty burst.
REQ-008 SHALL have ports: read_addr  output  ADDR_WIDTH  registered address to the synchronous RAM read port.
REQ-009 SHALL have ports: ram_data  input  DATA_WIDTH  RAM read data, valid one edge after read_addr is sampled.
REQ-010 SHALL have ports: out_valid, out_ready, out_data (DATA_WIDTH), out_last: output stream; out_ready is the only input.
REQ-011 SHALL have ports: busy  output  1  burst in progress; done  output  1  single-cycle completion pulse.

Function
REQ-012 SHALL have states IDLE and RUN: IDLE->RUN on start with length>0; RUN->IDLE on the edge the last word handshakes (out_valid & out_ready & out_last).
REQ-013 SHALL ignore start while in RUN; no sampling, no effect.
REQ-014 SHALL, for start with length=0, stay IDLE, drive no out_valid, and pulse done the cycle after start.
REQ-015 SHALL load read_addr<=base_addr on the start edge, then advance by 1 per issued address, wrapping modulo 2**ADDR_WIDTH.
REQ-016 SHALL treat RAM latency as exactly one edge; returned words are captured into a 2-entry output FIFO.
REQ-017 SHALL issue a new address only when FIFO occupancy plus in-flight reads, less this cycle's pop, is below 2; otherwise hold read_addr.
REQ-018 SHALL raise out_valid for the first word two edges after the start edge.
REQ-019 SHALL sustain one word per cycle while out_ready is held high.
REQ-020 SHALL hold out_data/out_last stable while out_valid & !out_ready, with no loss, duplication or reordering.
REQ-021 SHALL assert out_last only on word number length.
REQ-022 SHALL assert busy from the edge after start through the edge the last word handshakes, and pulse done for one cycle on that edge.
REQ-023 SHALL pass ram_data through unmodified; RAM read/write collision data is the RAM's responsibility.

Reset
REQ-024 SHALL, on reset (asynchronous, any time including mid-burst), enter IDLE, flush FIFO and in-flight reads, and drive read_addr=0, out_valid=0, out_data=0, out_last=0, busy=0, done=0.
REQ-025 SHALL accept start on the first clock edge after reset deasserts.

Configuration
REQ-026 SHALL, with macro RAM_READ_STREAMER_ABORT_EN defined, add input port abort (1 bit): abort high in RUN flushes FIFO and in-flight read on the next edge, returns to IDLE, drops out_valid, and pulses done; abort in IDLE is ignored.
REQ-027 SHALL, without RAM_READ_STREAMER_ABORT_EN, omit the abort port; a burst ends only by completion or reset.

Verification
REQ-028 SHALL cover: RAM preloaded ram[i]=i, base_addr=0x0010, length=4, out_ready=1 -> out_data 0x10,0x11,0x12,0x13 on consecutive cycles starting 2 edges after start; out_last on 0x13; done pulse once.
REQ-029 SHALL cover: length=8, out_ready toggling 1,0,0,1,... -> exactly 8 words in order; data held during stalls; FIFO never exceeds 2.
REQ-030 SHALL cover: base_addr=0xFFFE, length=4 -> read_addr sequence FFFE,FFFF,0000,0001; data matches those locations.
REQ-031 SHALL cover: length=0 -> no out_valid; done high exactly one cycle after start; busy stays 0.
REQ-032 SHALL cover: reset asserted mid-burst (word 3 of 8) -> all outputs 0 immediately; a new start after reset streams from the new base_addr.
REQ-033 SHALL cover, with RAM_READ_STREAMER_ABORT_EN: abort during word 2 of 6 -> out_valid low next edge, done pulses, no further words; next start streams normally.
